// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   owner_t      : current access owner (IDLE, OWN0, OWN1)
//   P0 / P1      : port index constants used as the winner encoding
//   *_DEF        : default widths and burst limit
//   burst_cnt_w  : width of the burst counter for a given burst limit
package dmem_arb_pkg;

    localparam int unsigned ADDR_W_DEF    = 7;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned MAX_BURST_DEF = 4;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    // A limit of 1 or 2 still needs one counter bit.
    function automatic int unsigned burst_cnt_w(input int unsigned max_burst);
        return (max_burst > 2) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin winner pick with burst ownership.
// Ports:
//   i_req0, i_req1     : requests (already gated by reset)
//   i_owner            : current owner
//   i_burst_at_limit   : owner has used up its contended burst allowance
//   i_last_served      : port granted most recently
//   o_winner           : winning port index (P0/P1), meaningful when o_valid
//   o_valid            : some port wins this cycle
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic   i_req0,
    input  logic   i_req1,
    input  owner_t i_owner,
    input  logic   i_burst_at_limit,
    input  logic   i_last_served,
    output logic   o_winner,
    output logic   o_valid
);

    always_comb begin
        o_valid  = i_req0 | i_req1;
        o_winner = P0;
        if (i_req0 && i_req1) begin
            if (i_owner == OWN0 && !i_burst_at_limit) begin
                o_winner = P0;
            end else if (i_owner == OWN1 && !i_burst_at_limit) begin
                o_winner = P1;
            end else begin
                o_winner = ~i_last_served;
            end
        end else if (i_req1) begin
            o_winner = P1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer in front of the data memory.
// Port 0 serves the pipeline MEM stage, port 1 a secondary master. One access
// is granted per cycle with zero-cycle arbitration latency; read data is
// registered back to the winning port one cycle after its grant.
// Ports:
//   i_clk, i_reset                 : clock, synchronous active-high reset
//   i_pX_req/we/addr/wdata         : port X request, write enable, address, data
//   o_pX_gnt                       : port X granted this cycle (combinational)
//   o_pX_rvalid / o_pX_rdata       : port X registered read response
//   o_mem_addr/wdata/read/write    : memory controls (all zero with no grant)
//   i_mem_rdata                    : combinational memory read data
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_p0_req,
    input  logic              i_p0_we,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic [DATA_W-1:0] i_p0_wdata,
    output logic              o_p0_gnt,
    output logic              o_p0_rvalid,
    output logic [DATA_W-1:0] o_p0_rdata,

    input  logic              i_p1_req,
    input  logic              i_p1_we,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [DATA_W-1:0] i_p1_wdata,
    output logic              o_p1_gnt,
    output logic              o_p1_rvalid,
    output logic [DATA_W-1:0] o_p1_rdata,

    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_read,
    output logic              o_mem_write,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int unsigned CntW = burst_cnt_w(MAX_BURST);
    localparam logic [CntW-1:0] BurstLim = CntW'(MAX_BURST - 1);

    owner_t          r_owner;
    owner_t          w_owner_d;
    logic [CntW-1:0] r_burst_cnt;
    logic [CntW-1:0] w_burst_cnt_d;
    logic            r_last_served;
    logic            w_last_served_d;
    logic            r_rv0;
    logic            r_rv1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic w_req0;
    logic w_req1;
    logic w_winner;
    logic w_valid;
    logic w_gnt0;
    logic w_gnt1;
    logic w_sel_we;
    logic w_burst_at_limit;
    owner_t w_win_owner;

    // Grants are blocked while reset is asserted.
    assign w_req0 = i_p0_req & ~i_reset;
    assign w_req1 = i_p1_req & ~i_reset;

    assign w_burst_at_limit = (r_burst_cnt >= BurstLim);

    rr_pick2 u_pick (
        .i_req0           (w_req0),
        .i_req1           (w_req1),
        .i_owner          (r_owner),
        .i_burst_at_limit (w_burst_at_limit),
        .i_last_served    (r_last_served),
        .o_winner         (w_winner),
        .o_valid          (w_valid)
    );

    assign w_gnt0 = w_valid & (w_winner == P0);
    assign w_gnt1 = w_valid & (w_winner == P1);
    assign o_p0_gnt = w_gnt0;
    assign o_p1_gnt = w_gnt1;

    // Memory drive, zeroed when nobody is granted.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        w_sel_we    = 1'b0;
        if (w_gnt0) begin
            o_mem_addr  = i_p0_addr;
            o_mem_wdata = i_p0_wdata;
            w_sel_we    = i_p0_we;
        end else if (w_gnt1) begin
            o_mem_addr  = i_p1_addr;
            o_mem_wdata = i_p1_wdata;
            w_sel_we    = i_p1_we;
        end
        o_mem_read  = w_valid & ~w_sel_we;
        o_mem_write = w_valid & w_sel_we;
    end

    // Ownership / burst next state.
    always_comb begin
        w_owner_d       = IDLE;
        w_burst_cnt_d   = '0;
        w_last_served_d = r_last_served;
        w_win_owner     = (w_winner == P1) ? OWN1 : OWN0;
        if (w_valid) begin
            w_last_served_d = w_winner;
            w_owner_d       = w_win_owner;
            if (r_owner == w_win_owner) begin
                w_burst_cnt_d = (r_burst_cnt == BurstLim) ? r_burst_cnt
                                                          : r_burst_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_owner       <= IDLE;
            r_burst_cnt   <= '0;
            r_last_served <= P1;
            r_rv0         <= 1'b0;
            r_rv1         <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
        end else begin
            r_owner       <= w_owner_d;
            r_burst_cnt   <= w_burst_cnt_d;
            r_last_served <= w_last_served_d;
            r_rv0         <= w_gnt0 & ~i_p0_we;
            r_rv1         <= w_gnt1 & ~i_p1_we;
            if (w_gnt0 && !i_p0_we) begin
                r_rdata0 <= i_mem_rdata;
            end
            if (w_gnt1 && !i_p1_we) begin
                r_rdata1 <= i_mem_rdata;
            end
        end
    end

    assign o_p0_rvalid = r_rv0;
    assign o_p1_rvalid = r_rv1;
    assign o_p0_rdata  = r_rdata0;
    assign o_p1_rdata  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 32-word memory model.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [6:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
    logic        tb_init;

    logic [31:0] mem [32];

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter u_dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_p0_req    (p0_req),
        .i_p0_we     (p0_we),
        .i_p0_addr   (p0_addr),
        .i_p0_wdata  (p0_wdata),
        .o_p0_gnt    (p0_gnt),
        .o_p0_rvalid (p0_rvalid),
        .o_p0_rdata  (p0_rdata),
        .i_p1_req    (p1_req),
        .i_p1_we     (p1_we),
        .i_p1_addr   (p1_addr),
        .i_p1_wdata  (p1_wdata),
        .o_p1_gnt    (p1_gnt),
        .o_p1_rvalid (p1_rvalid),
        .o_p1_rdata  (p1_rdata),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_read  (mem_read),
        .o_mem_write (mem_write),
        .i_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on posedge, preload word6=33, word2=0x22.
    assign mem_rdata = mem[mem_addr[6:2]];
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
            mem[6] <= 32'd33;
            mem[2] <= 32'h22;
        end else if (mem_write) begin
            mem[mem_addr[6:2]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle_reqs();
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        idle_reqs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic exp_p0 [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        idle_reqs();
        reset   = 1'b1;
        tb_init = 1'b1;
        repeat (2) @(negedge clk);
        tb_init = 1'b0;
        reset   = 1'b0;
        #1;
        check("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("rst_p0_rdata", p0_rdata, 32'd0);
        check("rst_p1_rdata", p1_rdata, 32'd0);
        check("rst_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
        check("rst_mem_ctl", {30'd0, mem_write, mem_read}, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);

        // Lone p0 read of word 6.
        @(negedge clk);
        p0_req = 1'b1; p0_addr = 7'd24;
        #1;
        check("t1_p0_gnt", 32'(p0_gnt), 32'd1);
        check("t1_p1_gnt", 32'(p1_gnt), 32'd0);
        check("t1_mem_read", 32'(mem_read), 32'd1);
        check("t1_mem_write", 32'(mem_write), 32'd0);
        check("t1_mem_addr", 32'(mem_addr), 32'd24);
        @(negedge clk);
        idle_reqs();
        #1;
        check("t1_p0_rvalid", 32'(p0_rvalid), 32'd1);
        check("t1_p0_rdata", p0_rdata, 32'd33);
        check("t1_p1_rvalid", 32'(p1_rvalid), 32'd0);
        check("t1_p1_rdata", p1_rdata, 32'd0);
        @(negedge clk);
        #1;
        check("t1_p0_rvalid_drop", 32'(p0_rvalid), 32'd0);
        check("t1_p0_rdata_hold", p0_rdata, 32'd33);

        // Simultaneous reads after reset: p0 first, then p1.
        reset_pulse();
        p0_req = 1'b1; p0_addr = 7'd24;
        p1_req = 1'b1; p1_addr = 7'd8;
        #1;
        check("t2_c0_p0_gnt", 32'(p0_gnt), 32'd1);
        check("t2_c0_p1_gnt", 32'(p1_gnt), 32'd0);
        @(negedge clk);
        p0_req = 1'b0;
        #1;
        check("t2_c1_p1_gnt", 32'(p1_gnt), 32'd1);
        check("t2_c1_p0_gnt", 32'(p0_gnt), 32'd0);
        check("t2_c1_p0_rvalid", 32'(p0_rvalid), 32'd1);
        check("t2_c1_p0_rdata", p0_rdata, 32'd33);
        check("t2_c1_p1_rvalid", 32'(p1_rvalid), 32'd0);
        @(negedge clk);
        idle_reqs();
        #1;
        check("t2_c2_p1_rvalid", 32'(p1_rvalid), 32'd1);
        check("t2_c2_p1_rdata", p1_rdata, 32'h22);
        check("t2_c2_p0_rvalid", 32'(p0_rvalid), 32'd0);

        // Continuous contention: four grants each, alternating.
        reset_pulse();
        p0_req = 1'b1; p0_addr = 7'd24;
        p1_req = 1'b1; p1_addr = 7'd8;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            check($sformatf("t3_p0_gnt_%0d", i), 32'(p0_gnt), 32'(exp_p0[i]));
            check($sformatf("t3_p1_gnt_%0d", i), 32'(p1_gnt), 32'(!exp_p0[i]));
        end
        @(negedge clk);
        idle_reqs();

        // p1 write then read-back of the same word.
        @(negedge clk);
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 7'd8; p1_wdata = 32'hDEADBEEF;
        #1;
        check("t4_p1_gnt_w", 32'(p1_gnt), 32'd1);
        check("t4_mem_write", 32'(mem_write), 32'd1);
        check("t4_mem_read_w", 32'(mem_read), 32'd0);
        check("t4_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("t4_mem_addr", 32'(mem_addr), 32'd8);
        @(negedge clk);
        p1_we = 1'b0;
        #1;
        check("t4_mem_read_r", 32'(mem_read), 32'd1);
        check("t4_mem_write_r", 32'(mem_write), 32'd0);
        check("t4_p1_rvalid_after_w", 32'(p1_rvalid), 32'd0);
        @(negedge clk);
        idle_reqs();
        #1;
        check("t4_p1_rvalid", 32'(p1_rvalid), 32'd1);
        check("t4_p1_rdata", p1_rdata, 32'hDEADBEEF);

        // Reset in the cycle after a p0 read grant, mid-burst.
        reset_pulse();
        p0_req = 1'b1; p0_addr = 7'd24;
        p1_req = 1'b1; p1_addr = 7'd8;
        #1;
        check("t5_a_p0_gnt", 32'(p0_gnt), 32'd1);
        @(negedge clk);
        #1;
        check("t5_b_p0_gnt", 32'(p0_gnt), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_rst_gnt_blocked", {30'd0, p1_gnt, p0_gnt}, 32'd0);
        check("t5_rst_mem_read", 32'(mem_read), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t5_p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("t5_p0_rdata", p0_rdata, 32'd0);
        check("t5_post_p0_gnt", 32'(p0_gnt), 32'd1);
        check("t5_post_p1_gnt", 32'(p1_gnt), 32'd0);
        @(negedge clk);
        idle_reqs();

        // Idle cycles, then a lone p1 request.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("t6_mem_ctl_%0d", i), {30'd0, mem_write, mem_read}, 32'd0);
            check($sformatf("t6_mem_addr_%0d", i), 32'(mem_addr), 32'd0);
            check($sformatf("t6_gnt_%0d", i), {30'd0, p1_gnt, p0_gnt}, 32'd0);
            check($sformatf("t6_rvalid_%0d", i), {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
        end
        @(negedge clk);
        p1_req = 1'b1; p1_addr = 7'd24;
        #1;
        check("t6_p1_gnt", 32'(p1_gnt), 32'd1);
        check("t6_p0_gnt", 32'(p0_gnt), 32'd0);
        check("t6_mem_addr_p1", 32'(mem_addr), 32'd24);
        @(negedge clk);
        idle_reqs();
        #1;
        check("t6_p1_rvalid", 32'(p1_rvalid), 32'd1);
        check("t6_p1_rdata", p1_rdata, 32'd33);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and access sequencer in front of the 128x32 data memory. Port 0 serves the pipeline MEM stage; port 1 serves a secondary master (debug/loader). The block grants one access per cycle and drives the memory's address, write-data and MemRead/MemWrite controls. It registers read data back to the winning port. A burst limit bounds how long one port can keep ownership while the other waits.

Parameters:
ADDR_W, 7, byte address width; memory uses addr[6:2] as word index.
DATA_W, 32, data word width.
MAX_BURST, 4, max consecutive grants to one owner while the other port requests (>=1).

Ports:
clk  input  1  system clock; all state on posedge.
reset  input  1  synchronous, active-high reset.
p0_req  input  1  port 0 access request (level, held until granted).
p0_we  input  1  port 0 write (1) / read (0).
p0_addr  input  ADDR_W  port 0 byte address.
p0_wdata  input  DATA_W  port 0 write data.
p0_gnt  output  1  port 0 granted this cycle (combinational).
p0_rvalid  output  1  port 0 read data valid (one-cycle pulse).
p0_rdata  output  DATA_W  port 0 read data.
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
mem_addr  output  ADDR_W  to memory address.
mem_wdata  output  DATA_W  to memory writeData.
mem_read  output  1  to memory MemRead.
mem_write  output  1  to memory MemWrite.
mem_rdata  input  DATA_W  from memory ReadData (combinational read).

Behaviour:
- State: owner in {IDLE, OWN0, OWN1}; last_served (1 bit); burst_cnt (clog2(MAX_BURST) bits); rv0/rv1 and rdata0/rdata1 registers.
- Reset values: owner=IDLE, last_served=1 (port 0 wins first tie), burst_cnt=0, p0_rvalid=p1_rvalid=0, p0_rdata=p1_rdata=0. With no req asserted, all gnt and mem controls are 0.
- Winner selection (combinational, each cycle):
  - Neither req: no grant.
  - One req: that port wins.
  - Both req, owner=OWNx, burst_cnt<MAX_BURST-1: x wins.
  - Both req, otherwise: the port != last_served wins.
- Grant: the winner's gnt=1 in the same cycle as its req, so an uncontended access has zero-cycle arbitration latency. At most one gnt is high per cycle.
- Memory drive: mem_addr/mem_wdata are muxed from the winner. mem_read = gnt & ~we; mem_write = gnt & we. With no grant, mem_addr=0, mem_wdata=0, mem_read=0, mem_write=0.
- Write: committed at the posedge ending the grant cycle. No response pulse.
- Read: at the posedge ending the grant cycle, pX_rdata <= mem_rdata and pX_rvalid <= 1. rvalid drops the next cycle unless the port is granted another read. Read latency is 1 cycle after gnt. rdata holds its value until the next read by that port.
- State update on grant to x:
  - If owner==OWNx: burst_cnt saturating +1.
  - Otherwise: owner<=OWNx, burst_cnt<=0.
  - In both cases last_served<=x.
- No grant: owner<=IDLE, burst_cnt<=0; last_served unchanged.
- Burst limit: after MAX_BURST consecutive contended grants to x, the other port receives the next grant. MAX_BURST=1 degenerates to strict alternation under contention.
- Uncontended port keeps being granted every cycle regardless of burst_cnt.
- Read-after-write same word, back-to-back grants: the read returns the newly written data, since the write commits before the read cycle.
- Address: addr[1:0] are passed through unchanged; alignment is the requester's responsibility.
- Reset asserted mid-burst or with a read pending: the pending rvalid is suppressed and all state returns to reset values on that edge. Grants are blocked while reset=1.

Decomposition:
- Shared package dmem_arb_pkg: owner_t enum (IDLE, OWN0, OWN1), ADDR_W/DATA_W defaults, port index constants P0=0/P1=1.
- One natural sub-module: rr_pick2, the combinational two-way round-robin winner pick (inputs req0, req1, owner, burst_at_limit, last_served; output winner, valid).
- Datapath muxing and response registers stay in dmem_arbiter.

Test Plan:
- Memory preloaded word6=33. p0 read addr 24 alone -> p0_gnt=1 that cycle, mem_read=1, mem_addr=24. Next cycle p0_rvalid=1, p0_rdata=33. p1 outputs stay 0.
- After reset, p0 and p1 both request reads in the same cycle -> p0 granted first, p1 granted the next cycle. Each rvalid arrives one cycle after its own gnt.
- MAX_BURST=4, p0 and p1 request continuously -> grant pattern p0,p0,p0,p0,p1,p1,p1,p1,p0… Never two gnts in one cycle.
- p1 write 0xDEADBEEF to addr 8, then p1 read addr 8 next cycle -> mem_write pulse, then p1_rvalid with p1_rdata=0xDEADBEEF.
- Reset asserted during p0 burst in the cycle after a read grant -> p0_rvalid=0, p0_rdata=0. With both ports then requesting, the next grant goes to p0.
- No requests for 5 cycles -> mem_read=mem_write=0, mem_addr=0, all gnt/rvalid=0. A subsequent lone p1 request is granted immediately.
